// File: rtl/render_pkg.sv
// Shared constants for the render update controller: register map,
// field positions inside the shadow/active words, and FSM encoding.
package render_pkg;

  localparam logic [1:0] REG_PLAYER  = 2'd0;
  localparam logic [1:0] REG_BULLET  = 2'd1;
  localparam logic [1:0] REG_STATE   = 2'd2;
  localparam logic [1:0] REG_INVALID = 2'd3;

  localparam int unsigned POS_W            = 16;
  localparam int unsigned BULLET_COLOR_LSB = 16;
  localparam int unsigned BULLET_COLOR_W   = 2;
  localparam int unsigned IS_RENDER_BIT    = 18;
  localparam int unsigned BULLET_W         = 19;
  localparam int unsigned STATE_W          = 32;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_COMMIT = 1'b1
  } ctrl_state_t;

  // Index of the set bit in a 3-bit one-hot vector (0 when empty).
  function automatic logic [1:0] onehot3_to_idx(input logic [2:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    if (oh[1]) idx = 2'd1;
    if (oh[2]) idx = 2'd2;
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter. Grant is combinational; the search starts
// one past the most recently served requester.
module rr_arbiter3
  import render_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       advance,
  output logic [2:0] grant
);

  logic [1:0]  r_last_grant;
  logic        w_found;
  logic [1:0]  w_idx;
  int unsigned w_pos;

  // Pick the first requesting index in rotation order after r_last_grant.
  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    w_idx   = '0;
    for (int unsigned k = 1; k <= 3; k++) begin
      w_pos = 32'(r_last_grant) + k;
      if (w_pos >= 3) w_pos = w_pos - 3;
      w_idx = 2'(w_pos);
      if (!w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

  // Remember who was served so the next search begins after them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 2'd2;
    end else if (advance) begin
      r_last_grant <= onehot3_to_idx(grant);
    end
  end

endmodule

// File: rtl/render_update_ctrl.sv
// Double-buffered render register bank: requesters write a shadow bank via
// a round-robin arbiter; a vsync rising edge triggers a one-cycle commit of
// shadow into the active bank driving the renderer.
module render_update_ctrl
  import render_pkg::*;
#(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vsync,
  input  logic                 hold,
  input  logic [NREQ-1:0]      wr_valid,
  input  logic [2*NREQ-1:0]    wr_addr,
  input  logic [32*NREQ-1:0]   wr_data,
  output logic [NREQ-1:0]      wr_ready,
  output logic [15:0]          player_pos,
  output logic [15:0]          bullet_pos,
  output logic [1:0]           bullet_color,
  output logic                 is_render,
  output logic [31:0]          game_state,
  output logic                 frame_tick,
  output logic [CNT_W-1:0]     frame_count,
  output logic                 dirty,
  output logic                 err
);

  ctrl_state_t         r_state, w_state_nxt;
  logic                r_vsync_q;
  logic                w_rise, w_commit, w_xfer;
  logic [2:0]          w_arb_req, w_grant;
  logic [1:0]          w_addr;
  logic [31:0]         w_data;

  logic [POS_W-1:0]    r_sh_player, r_act_player;
  logic [BULLET_W-1:0] r_sh_bullet, r_act_bullet;
  logic [STATE_W-1:0]  r_sh_state,  r_act_state;
  logic [CNT_W-1:0]    r_frame_count;
  logic                r_dirty, r_err;

  assign w_rise    = vsync & ~r_vsync_q;
  // Requests only reach the arbiter in ARB and never while reset is high.
  assign w_arb_req = (r_state == ST_ARB && !reset) ? wr_valid : '0;
  assign wr_ready  = w_grant;
  assign w_xfer    = |w_grant;

  rr_arbiter3 u_arb (
    .clk     (clk),
    .rst     (reset),
    .req     (w_arb_req),
    .advance (w_xfer),
    .grant   (w_grant)
  );

  // Route the granted requester's address and data to the shadow write port.
  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_addr = wr_addr[2*i +: 2];
        w_data = wr_data[32*i +: 32];
      end
    end
  end

  // Next-state logic: a vsync rise in ARB schedules exactly one commit cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    case (r_state)
      ST_ARB:    if (w_rise) w_state_nxt = ST_COMMIT;
      ST_COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = ST_ARB;
      end
      default:   w_state_nxt = ST_ARB;
    endcase
  end

  // State register and vsync edge-detect history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_ARB;
      r_vsync_q <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_vsync_q <= vsync;
    end
  end

  // Shadow bank writes, dirty tracking and sticky invalid-address error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh_player <= '0;
      r_sh_bullet <= '0;
      r_sh_state  <= '0;
      r_dirty     <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_xfer) begin
      r_dirty <= 1'b1;
      case (w_addr)
        REG_PLAYER: r_sh_player <= w_data[POS_W-1:0];
        REG_BULLET: r_sh_bullet <= w_data[BULLET_W-1:0];
        REG_STATE:  r_sh_state  <= w_data;
        default:    r_err       <= 1'b1;
      endcase
    end else if (w_commit && !hold) begin
      r_dirty <= 1'b0;
    end
  end

  // Active bank copy and frame counter, both updated only by a commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_act_player  <= '0;
      r_act_bullet  <= '0;
      r_act_state   <= '0;
      r_frame_count <= '0;
    end else if (w_commit) begin
      r_frame_count <= r_frame_count + 1'b1;
      if (!hold) begin
        r_act_player <= r_sh_player;
        r_act_bullet <= r_sh_bullet;
        r_act_state  <= r_sh_state;
      end
    end
  end

  assign player_pos   = r_act_player;
  assign bullet_pos   = r_act_bullet[POS_W-1:0];
  assign bullet_color = r_act_bullet[BULLET_COLOR_LSB +: BULLET_COLOR_W];
  assign is_render    = r_act_bullet[IS_RENDER_BIT];
  assign game_state   = r_act_state;
  assign frame_tick   = (r_state == ST_COMMIT);
  assign frame_count  = r_frame_count;
  assign dirty        = r_dirty;
  assign err          = r_err;

endmodule

// File: tb/tb_render_update_ctrl.sv
// Directed self-checking bench for render_update_ctrl: a table of
// write/commit vectors plus hand sequences for arbitration, vsync edge
// handling, counter wrap and reset during commit.
module tb_render_update_ctrl;

  // Narrow counter keeps the wrap test short.
  localparam int unsigned CW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          vsync;
  logic          hold;
  logic [2:0]    wr_valid;
  logic [5:0]    wr_addr;
  logic [95:0]   wr_data;
  logic [2:0]    wr_ready;
  logic [15:0]   player_pos;
  logic [15:0]   bullet_pos;
  logic [1:0]    bullet_color;
  logic          is_render;
  logic [31:0]   game_state;
  logic          frame_tick;
  logic [CW-1:0] frame_count;
  logic          dirty;
  logic          err;

  int checks = 0;
  int errors = 0;

  render_update_ctrl #(.NREQ(3), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .vsync        (vsync),
    .hold         (hold),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .player_pos   (player_pos),
    .bullet_pos   (bullet_pos),
    .bullet_color (bullet_color),
    .is_render    (is_render),
    .game_state   (game_state),
    .frame_tick   (frame_tick),
    .frame_count  (frame_count),
    .dirty        (dirty),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          req;
    logic [1:0]  addr;
    logic [31:0] data;
    logic        hold;
    logic [15:0] e_player;
    logic [15:0] e_bullet;
    logic [1:0]  e_color;
    logic        e_render;
    logic [31:0] e_state;
    logic        e_dirty;
    logic        e_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    vsync    = 1'b0;
    hold     = 1'b0;
    wr_valid = 3'b111;
    wr_addr  = '0;
    wr_data  = '0;
    step();
    chk("ready_in_reset", 64'(wr_ready), 64'h0);
    step();
    reset    = 1'b0;
    wr_valid = '0;
  endtask

  // Single requester write; bounded wait for its grant.
  task automatic do_write(input int r, input logic [1:0] a, input logic [31:0] d);
    bit got;
    got = 1'b0;
    wr_valid = 3'b001 << r;
    wr_addr[2*r +: 2]   = a;
    wr_data[32*r +: 32] = d;
    for (int k = 0; k < 8 && !got; k++) begin
      #1;
      if (wr_ready[r]) got = 1'b1;
      step();
    end
    wr_valid = '0;
    chk("write_granted", 64'(got), 64'h1);
  endtask

  // One vsync pulse: rise cycle, then the commit cycle.
  task automatic do_frame(input logic h);
    hold  = h;
    vsync = 1'b1;
    step();
    chk("tick_in_commit", 64'(frame_tick), 64'h1);
    chk("ready_in_commit", 64'(wr_ready), 64'h0);
    vsync = 1'b0;
    step();
    chk("tick_after_commit", 64'(frame_tick), 64'h0);
    hold = 1'b0;
  endtask

  initial begin
    logic [2:0] rr_exp [6];
    int ticks;

    vecs[0] = '{0, 2'd0, 32'h0000_3C50, 1'b0, 16'h3C50, 16'h0000, 2'd0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    vecs[1] = '{2, 2'd2, 32'h9000_6464, 1'b1, 16'h3C50, 16'h0000, 2'd0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{1, 2'd1, 32'hFFFF_ABCD, 1'b0, 16'h3C50, 16'hABCD, 2'd3, 1'b1, 32'h9000_6464, 1'b0, 1'b0};
    vecs[3] = '{1, 2'd3, 32'h1234_5678, 1'b0, 16'h3C50, 16'hABCD, 2'd3, 1'b1, 32'h9000_6464, 1'b0, 1'b1};
    vecs[4] = '{0, 2'd1, 32'h0002_1122, 1'b0, 16'h3C50, 16'h1122, 2'd2, 1'b0, 32'h9000_6464, 1'b0, 1'b1};
    vecs[5] = '{2, 2'd0, 32'hDEAD_0007, 1'b0, 16'h0007, 16'h1122, 2'd2, 1'b0, 32'h9000_6464, 1'b0, 1'b1};
    rr_exp  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    // Reset state.
    do_reset();
    #1;
    chk("rst_player", 64'(player_pos), 64'h0);
    chk("rst_state", 64'(game_state), 64'h0);
    chk("rst_count", 64'(frame_count), 64'h0);
    chk("rst_tick", 64'(frame_tick), 64'h0);
    chk("rst_dirty", 64'(dirty), 64'h0);
    chk("rst_err", 64'(err), 64'h0);

    // Round robin with all three requesters continuously valid.
    wr_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("rr_grant_%0d", i), 64'(wr_ready), 64'(rr_exp[i]));
      step();
    end
    wr_valid = '0;

    // Table of write + commit vectors.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      do_write(vecs[i].req, vecs[i].addr, vecs[i].data);
      do_frame(vecs[i].hold);
      chk($sformatf("v%0d_player", i), 64'(player_pos), 64'(vecs[i].e_player));
      chk($sformatf("v%0d_bullet", i), 64'(bullet_pos), 64'(vecs[i].e_bullet));
      chk($sformatf("v%0d_color", i), 64'(bullet_color), 64'(vecs[i].e_color));
      chk($sformatf("v%0d_render", i), 64'(is_render), 64'(vecs[i].e_render));
      chk($sformatf("v%0d_state", i), 64'(game_state), 64'(vecs[i].e_state));
      chk($sformatf("v%0d_dirty", i), 64'(dirty), 64'(vecs[i].e_dirty));
      chk($sformatf("v%0d_err", i), 64'(err), 64'(vecs[i].e_err));
      chk($sformatf("v%0d_count", i), 64'(frame_count), 64'(i + 1));
    end

    // Write accepted in the same cycle as the vsync rise joins that commit.
    wr_valid       = 3'b001;
    wr_addr[1:0]   = 2'd2;
    wr_data[31:0]  = 32'h0BAD_F00D;
    vsync          = 1'b1;
    #1;
    chk("rise_write_ready", 64'(wr_ready), 64'h1);
    step();
    wr_valid = '0;
    vsync    = 1'b0;
    chk("rise_write_commit_ready", 64'(wr_ready), 64'h0);
    chk("rise_write_state_before", 64'(game_state), 64'h9000_6464);
    step();
    chk("rise_write_state", 64'(game_state), 64'h0BAD_F00D);
    chk("rise_write_count", 64'(frame_count), 64'd7);

    // vsync held high for 10 cycles gives a single commit.
    ticks = 0;
    vsync = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 10) vsync = 1'b0;
      step();
      if (frame_tick) ticks++;
    end
    chk("long_vsync_ticks", 64'(ticks), 64'h1);
    chk("long_vsync_count", 64'(frame_count), 64'd8);

    // Counter wrap.
    do_reset();
    for (int i = 0; i < (1 << CW) - 1; i++) begin
      vsync = 1'b1;
      step();
      vsync = 1'b0;
      step();
    end
    chk("count_max", 64'(frame_count), 64'((1 << CW) - 1));
    do_frame(1'b0);
    chk("count_wrap", 64'(frame_count), 64'h0);

    // Reset asserted in the middle of a commit.
    do_write(0, 2'd0, 32'h0000_1111);
    do_write(1, 2'd2, 32'h2222_3333);
    do_frame(1'b0);
    chk("pre_rst_player", 64'(player_pos), 64'h1111);
    do_write(2, 2'd1, 32'h0000_4444);
    vsync = 1'b1;
    step();
    chk("pre_rst_tick", 64'(frame_tick), 64'h1);
    reset    = 1'b1;
    vsync    = 1'b0;
    wr_valid = 3'b111;
    #1;
    chk("mid_rst_tick", 64'(frame_tick), 64'h0);
    chk("mid_rst_ready", 64'(wr_ready), 64'h0);
    chk("mid_rst_player", 64'(player_pos), 64'h0);
    chk("mid_rst_state", 64'(game_state), 64'h0);
    chk("mid_rst_count", 64'(frame_count), 64'h0);
    chk("mid_rst_dirty", 64'(dirty), 64'h0);
    step();
    chk("mid_rst_tick_next", 64'(frame_tick), 64'h0);
    reset = 1'b0;
    #1;
    chk("post_rst_first_grant", 64'(wr_ready), 64'h1);
    step();
    wr_valid = '0;
    #1;
    chk("post_rst_no_commit", 64'(frame_count), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
